control_pipe: RTL and testbench
===============================

Name: control_pipe

Overview:
Consumer side of the opcode decoder's control bundle. Carries the decoded control signals and register addresses through the ID/EX, EX/MEM and MEM/WB pipeline registers. Detects load-use hazards and raises a stall. Applies a branch flush. Generates EX-stage forwarding selects for the operand muxes. Sits beside the datapath pipeline registers and is the only place control bubbles are created.

Parameters:
REG_ADDR_W, 5, register-address width
ALU_OP_W, 3, width of the ALU operation code from the decoder

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Branch_i  input  1  ID-stage decoded branch
Mem_Read_i  input  1  ID-stage decoded load
Mem_to_Reg_i  input  1  ID-stage writeback source select
Mem_Write_i  input  1  ID-stage decoded store
ALU_Src_i  input  1  ID-stage immediate operand select
Reg_Write_i  input  1  ID-stage register write enable
ALU_Op_i  input  ALU_OP_W  ID-stage ALU operation code
Rs1_i, Rs2_i, Rd_i  input  REG_ADDR_W each  ID-stage register addresses
Branch_Taken_i  input  1  branch in EX resolved taken (from datapath)
Branch_EX_o, ALU_Src_EX_o  output  1 each  EX-stage control
ALU_Op_EX_o  output  ALU_OP_W  EX-stage ALU operation code
Rd_EX_o  output  REG_ADDR_W  EX-stage destination register
Mem_Read_MEM_o, Mem_Write_MEM_o, Reg_Write_MEM_o  output  1 each  MEM-stage control
Rd_MEM_o  output  REG_ADDR_W  MEM-stage destination register
Mem_to_Reg_WB_o, Reg_Write_WB_o  output  1 each  WB-stage control
Rd_WB_o  output  REG_ADDR_W  WB-stage destination register
Forward_A_o, Forward_B_o  output  2 each  EX operand forwarding selects
Stall_o  output  1  hold PC and IF/ID register
Flush_o  output  1  clear IF/ID register

Behaviour:
- Reset (async, immediate): all pipeline registers clear to 0. Every registered output is 0. Stall_o, Flush_o and Forward_*_o evaluate to 0 because the register state is zero.
- Latency: a bundle presented at ID on edge N appears at EX outputs after N, at MEM after N+1, at WB after N+2.
- Rs1/Rs2 are registered into ID/EX internally and used only for forwarding. Mem_Read_EX and Reg_Write_EX are kept internally.
- Load-use stall is combinational: Stall_o = Mem_Read_EX & (Rd_EX != 0) & (Rd_EX == Rs1_i | Rd_EX == Rs2_i) & ~Branch_Taken_i.
- Flush_o = Branch_Taken_i, combinational.
- Bubble: on an edge with Stall_o or Flush_o high, ID/EX loads all zeros (controls, Rd, Rs1, Rs2). EX/MEM and MEM/WB always advance.
- Flush has priority over stall. A simultaneous flush and stall produces one bubble and Stall_o=0.
- Forward_A_o priority:
  - 2'b10 if Reg_Write_MEM & Rd_MEM != 0 & Rd_MEM == Rs1_EX;
  - else 2'b01 if Reg_Write_WB & Rd_WB != 0 & Rd_WB == Rs1_EX;
  - else 2'b00.
  - Forward_B_o uses the same rule with Rs2_EX.
- x0 never triggers a stall or forwarding. Reg_Write to x0 is passed through unchanged.
- An all-zero bundle (unrecognised opcode) propagates as a natural bubble.
- Reset asserted mid-stream drops all in-flight bundles. No partial state survives deassertion.

Decomposition:
- Shared package: stage bundle widths, FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and the bubble constant (all zeros).
- One natural sub-module: pipe_stage_reg, a parameterised-width register with async active-high reset and a synchronous bubble input. It is instantiated three times.
- Hazard and forwarding logic stays inline.

Test Plan:
- R-type bundle Reg_Write=1, ALU_Op=000, Rd=5 at cycle 0 -> Rd_EX_o=5 at cycle 1, Reg_Write_MEM_o=1/Rd_MEM_o=5 at cycle 2, Reg_Write_WB_o=1/Rd_WB_o=5 at cycle 3.
- Load Rd=7 in EX, ID bundle with Rs2=7 -> Stall_o=1 same cycle. Next cycle EX outputs all 0 and Rd_EX_o=0, Mem_Read_MEM_o=1, Rd_MEM_o=7. Stall_o=0 afterwards.
- Load Rd=0 in EX, ID Rs1=0 -> Stall_o=0. Bundle advances normally.
- Writers to x3 in both MEM and WB, EX Rs1=3 -> Forward_A_o=10. Writer to x4 in WB only, EX Rs2=4 -> Forward_B_o=01. Reg_Write_MEM=0 with Rd_MEM=3 -> no MEM forward.
- Branch_Taken_i=1 while the ID bundle has load-use with EX -> Flush_o=1, Stall_o=0. Next cycle EX outputs all 0.
- Reset pulse asserted between edges with three bundles in flight -> all outputs 0 immediately, before the next edge. After deassertion, first new bundle appears at EX one edge later.

Source files
------------

// File: rtl/control_pipe_pkg.sv
// Shared types and constants for the control pipeline: per-stage control bundles,
// forwarding-select encodings and the all-zero bubble values.
package control_pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 3;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef struct packed {
        logic                  branch;
        logic                  mem_read;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_write;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
    } id_ex_t;

    typedef struct packed {
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } mem_wb_t;

    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    localparam id_ex_t  ID_EX_BUBBLE  = '0;
    localparam ex_mem_t EX_MEM_BUBBLE = '0;
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/control_pipe_if.sv
// Signal bundle between the decoder/datapath side (master) and control_pipe (slave).
interface control_pipe_if;
    import control_pipe_pkg::*;

    logic                  Branch_i;
    logic                  Mem_Read_i;
    logic                  Mem_to_Reg_i;
    logic                  Mem_Write_i;
    logic                  ALU_Src_i;
    logic                  Reg_Write_i;
    logic [ALU_OP_W-1:0]   ALU_Op_i;
    logic [REG_ADDR_W-1:0] Rs1_i;
    logic [REG_ADDR_W-1:0] Rs2_i;
    logic [REG_ADDR_W-1:0] Rd_i;
    logic                  Branch_Taken_i;
    logic                  Branch_EX_o;
    logic                  ALU_Src_EX_o;
    logic [ALU_OP_W-1:0]   ALU_Op_EX_o;
    logic [REG_ADDR_W-1:0] Rd_EX_o;
    logic                  Mem_Read_MEM_o;
    logic                  Mem_Write_MEM_o;
    logic                  Reg_Write_MEM_o;
    logic [REG_ADDR_W-1:0] Rd_MEM_o;
    logic                  Mem_to_Reg_WB_o;
    logic                  Reg_Write_WB_o;
    logic [REG_ADDR_W-1:0] Rd_WB_o;
    logic [1:0]            Forward_A_o;
    logic [1:0]            Forward_B_o;
    logic                  Stall_o;
    logic                  Flush_o;

    modport master (
        output Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i, ALU_Src_i, Reg_Write_i,
               ALU_Op_i, Rs1_i, Rs2_i, Rd_i, Branch_Taken_i,
        input  Branch_EX_o, ALU_Src_EX_o, ALU_Op_EX_o, Rd_EX_o, Mem_Read_MEM_o,
               Mem_Write_MEM_o, Reg_Write_MEM_o, Rd_MEM_o, Mem_to_Reg_WB_o,
               Reg_Write_WB_o, Rd_WB_o, Forward_A_o, Forward_B_o, Stall_o, Flush_o
    );

    modport slave (
        input  Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i, ALU_Src_i, Reg_Write_i,
               ALU_Op_i, Rs1_i, Rs2_i, Rd_i, Branch_Taken_i,
        output Branch_EX_o, ALU_Src_EX_o, ALU_Op_EX_o, Rd_EX_o, Mem_Read_MEM_o,
               Mem_Write_MEM_o, Reg_Write_MEM_o, Rd_MEM_o, Mem_to_Reg_WB_o,
               Reg_Write_WB_o, Rd_WB_o, Forward_A_o, Forward_B_o, Stall_o, Flush_o
    );

endinterface

// File: rtl/control_pipe_stage_reg.sv
// Generic pipeline register: async active-high clear, synchronous bubble insertion.
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Stage register; a bubble loads zeros so downstream sees a no-op bundle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= {W{1'b0}};
        end else if (bubble_i) begin
            data_q <= {W{1'b0}};
        end else begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/control_pipe.sv
// Control-side pipeline registers (ID/EX, EX/MEM, MEM/WB) with load-use stall,
// branch flush and EX-stage forwarding selects.
module control_pipe
    import control_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    control_pipe_if.slave   bus
);

    id_ex_t  id_ex_d, id_ex_q;
    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;
    logic    stall_s;
    logic    flush_s;
    logic    bubble_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    // Next-state bundles for each stage register
    always_comb begin
        id_ex_d            = ID_EX_BUBBLE;
        id_ex_d.branch     = bus.Branch_i;
        id_ex_d.mem_read   = bus.Mem_Read_i;
        id_ex_d.mem_to_reg = bus.Mem_to_Reg_i;
        id_ex_d.mem_write  = bus.Mem_Write_i;
        id_ex_d.alu_src    = bus.ALU_Src_i;
        id_ex_d.reg_write  = bus.Reg_Write_i;
        id_ex_d.alu_op     = bus.ALU_Op_i;
        id_ex_d.rd         = bus.Rd_i;
        id_ex_d.rs1        = bus.Rs1_i;
        id_ex_d.rs2        = bus.Rs2_i;

        ex_mem_d            = EX_MEM_BUBBLE;
        ex_mem_d.mem_read   = id_ex_q.mem_read;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.rd         = id_ex_q.rd;

        mem_wb_d            = MEM_WB_BUBBLE;
        mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
        mem_wb_d.reg_write  = ex_mem_q.reg_write;
        mem_wb_d.rd         = ex_mem_q.rd;
    end

    // A taken branch masks the stall so the pair yields a single bubble
    assign flush_s  = bus.Branch_Taken_i;
    assign stall_s  = id_ex_q.mem_read
                    & (id_ex_q.rd != {REG_ADDR_W{1'b0}})
                    & ((id_ex_q.rd == bus.Rs1_i) | (id_ex_q.rd == bus.Rs2_i))
                    & ~bus.Branch_Taken_i;
    assign bubble_s = stall_s | flush_s;

    pipe_stage_reg #(.W(ID_EX_W)) u_id_ex (
        .clk(clk), .reset(reset), .bubble_i(bubble_s), .d_i(id_ex_d), .q_o(id_ex_q)
    );

    pipe_stage_reg #(.W(EX_MEM_W)) u_ex_mem (
        .clk(clk), .reset(reset), .bubble_i(1'b0), .d_i(ex_mem_d), .q_o(ex_mem_q)
    );

    pipe_stage_reg #(.W(MEM_WB_W)) u_mem_wb (
        .clk(clk), .reset(reset), .bubble_i(1'b0), .d_i(mem_wb_d), .q_o(mem_wb_q)
    );

    // Forwarding selects: the younger MEM result wins over WB; x0 never forwards
    always_comb begin
        fwd_a_s = FWD_NONE;
        fwd_b_s = FWD_NONE;
        if (ex_mem_q.reg_write && (ex_mem_q.rd != {REG_ADDR_W{1'b0}}) && (ex_mem_q.rd == id_ex_q.rs1)) begin
            fwd_a_s = FWD_MEM;
        end else if (mem_wb_q.reg_write && (mem_wb_q.rd != {REG_ADDR_W{1'b0}}) && (mem_wb_q.rd == id_ex_q.rs1)) begin
            fwd_a_s = FWD_WB;
        end else begin
            fwd_a_s = FWD_NONE;
        end
        if (ex_mem_q.reg_write && (ex_mem_q.rd != {REG_ADDR_W{1'b0}}) && (ex_mem_q.rd == id_ex_q.rs2)) begin
            fwd_b_s = FWD_MEM;
        end else if (mem_wb_q.reg_write && (mem_wb_q.rd != {REG_ADDR_W{1'b0}}) && (mem_wb_q.rd == id_ex_q.rs2)) begin
            fwd_b_s = FWD_WB;
        end else begin
            fwd_b_s = FWD_NONE;
        end
    end

    assign bus.Branch_EX_o     = id_ex_q.branch;
    assign bus.ALU_Src_EX_o    = id_ex_q.alu_src;
    assign bus.ALU_Op_EX_o     = id_ex_q.alu_op;
    assign bus.Rd_EX_o         = id_ex_q.rd;
    assign bus.Mem_Read_MEM_o  = ex_mem_q.mem_read;
    assign bus.Mem_Write_MEM_o = ex_mem_q.mem_write;
    assign bus.Reg_Write_MEM_o = ex_mem_q.reg_write;
    assign bus.Rd_MEM_o        = ex_mem_q.rd;
    assign bus.Mem_to_Reg_WB_o = mem_wb_q.mem_to_reg;
    assign bus.Reg_Write_WB_o  = mem_wb_q.reg_write;
    assign bus.Rd_WB_o         = mem_wb_q.rd;
    assign bus.Forward_A_o     = fwd_a_s;
    assign bus.Forward_B_o     = fwd_b_s;
    assign bus.Stall_o         = stall_s;
    assign bus.Flush_o         = flush_s;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: latency, load-use stall, flush, forwarding, reset.
module tb_control_pipe;
    import control_pipe_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    control_pipe_if bus();

    control_pipe dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an ID bundle: {branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write}
    task automatic drive(input logic [5:0] ctl, input logic [2:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        bus.Branch_i     = ctl[5];
        bus.Mem_Read_i   = ctl[4];
        bus.Mem_to_Reg_i = ctl[3];
        bus.Mem_Write_i  = ctl[2];
        bus.ALU_Src_i    = ctl[1];
        bus.Reg_Write_i  = ctl[0];
        bus.ALU_Op_i     = op;
        bus.Rd_i         = rd;
        bus.Rs1_i        = rs1;
        bus.Rs2_i        = rs2;
    endtask

    function automatic logic [31:0] regs_all();
        return {7'd0, bus.Branch_EX_o, bus.ALU_Src_EX_o, bus.ALU_Op_EX_o, bus.Rd_EX_o,
                bus.Mem_Read_MEM_o, bus.Mem_Write_MEM_o, bus.Reg_Write_MEM_o, bus.Rd_MEM_o,
                bus.Mem_to_Reg_WB_o, bus.Reg_Write_WB_o, bus.Rd_WB_o};
    endfunction

    function automatic logic [31:0] comb_all();
        return {26'd0, bus.Stall_o, bus.Flush_o, bus.Forward_A_o, bus.Forward_B_o};
    endfunction

    function automatic logic [31:0] ex_all();
        return {22'd0, bus.Branch_EX_o, bus.ALU_Src_EX_o, bus.ALU_Op_EX_o, bus.Rd_EX_o};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.Branch_Taken_i = 1'b0;
        drive(6'b000001, 3'd0, 5'd9, 5'd9, 5'd9);
        #12;
        check("reset_regs", regs_all(), 32'd0);
        check("reset_comb", comb_all(), 32'd0);
        reset = 1'b0;
        drive(6'b000000, 3'd0, 5'd0, 5'd0, 5'd0);
        tick();

        // R-type latency through EX, MEM, WB
        drive(6'b000001, 3'd0, 5'd5, 5'd1, 5'd2);
        tick();
        drive(6'b000000, 3'd0, 5'd0, 5'd0, 5'd0);
        check("rtype_ex_rd", {27'd0, bus.Rd_EX_o}, 32'd5);
        check("rtype_ex_op", {29'd0, bus.ALU_Op_EX_o}, 32'd0);
        tick();
        check("rtype_mem", {26'd0, bus.Reg_Write_MEM_o, bus.Rd_MEM_o}, {26'd0, 1'b1, 5'd5});
        tick();
        check("rtype_wb", {26'd0, bus.Reg_Write_WB_o, bus.Rd_WB_o}, {26'd0, 1'b1, 5'd5});

        // Load x7 then consumer on Rs2=7
        drive(6'b011001, 3'd0, 5'd7, 5'd1, 5'd0);
        tick();
        drive(6'b000001, 3'd0, 5'd8, 5'd1, 5'd7);
        #1;
        check("lu_stall", {31'd0, bus.Stall_o}, 32'd1);
        check("lu_flush", {31'd0, bus.Flush_o}, 32'd0);
        tick();
        check("lu_bubble_ex", ex_all(), 32'd0);
        check("lu_mem", {26'd0, bus.Mem_Read_MEM_o, bus.Rd_MEM_o}, {26'd0, 1'b1, 5'd7});
        check("lu_stall_clr", {31'd0, bus.Stall_o}, 32'd0);
        tick();
        drive(6'b000000, 3'd0, 5'd0, 5'd0, 5'd0);
        check("lu_adv_rd", {27'd0, bus.Rd_EX_o}, 32'd8);
        check("lu_fwd_b_wb", {30'd0, bus.Forward_B_o}, {30'd0, FWD_WB});
        check("lu_fwd_a", {30'd0, bus.Forward_A_o}, {30'd0, FWD_NONE});

        // Load to x0 never stalls
        drive(6'b011001, 3'd0, 5'd0, 5'd2, 5'd0);
        tick();
        drive(6'b000011, 3'd5, 5'd9, 5'd0, 5'd0);
        #1;
        check("x0_nostall", {31'd0, bus.Stall_o}, 32'd0);
        tick();
        drive(6'b000000, 3'd0, 5'd0, 5'd0, 5'd0);
        check("x0_adv", ex_all(), {22'd0, 1'b0, 1'b1, 3'd5, 5'd9});

        // Forwarding: two writers of x3, then writer of x4 seen from WB
        drive(6'b000001, 3'd0, 5'd3, 5'd0, 5'd0);
        tick();
        drive(6'b000001, 3'd0, 5'd3, 5'd0, 5'd0);
        tick();
        drive(6'b000001, 3'd0, 5'd4, 5'd3, 5'd0);
        tick();
        check("fwd_a_mem", {30'd0, bus.Forward_A_o}, {30'd0, FWD_MEM});
        check("fwd_b_none", {30'd0, bus.Forward_B_o}, {30'd0, FWD_NONE});
        drive(6'b000000, 3'd0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(6'b000000, 3'd0, 5'd0, 5'd3, 5'd4);
        tick();
        check("fwd_b_wb", {30'd0, bus.Forward_B_o}, {30'd0, FWD_WB});
        check("fwd_a_x3_gone", {30'd0, bus.Forward_A_o}, {30'd0, FWD_NONE});
        drive(6'b000100, 3'd0, 5'd3, 5'd0, 5'd0);
        tick();
        drive(6'b000000, 3'd0, 5'd0, 5'd3, 5'd0);
        tick();
        check("nofwd_rw0", {30'd0, bus.Forward_A_o}, {30'd0, FWD_NONE});
        check("nofwd_rw0_mem", {25'd0, bus.Mem_Write_MEM_o, bus.Reg_Write_MEM_o, bus.Rd_MEM_o},
              {25'd0, 1'b1, 1'b0, 5'd3});
        drive(6'b000001, 3'd0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(6'b000000, 3'd0, 5'd0, 5'd0, 5'd0);
        tick();
        check("x0_write_pass", {26'd0, bus.Reg_Write_MEM_o, bus.Rd_MEM_o}, {26'd0, 1'b1, 5'd0});
        check("x0_nofwd", comb_all(), 32'd0);

        // Taken branch together with a load-use hazard
        drive(6'b011001, 3'd0, 5'd6, 5'd0, 5'd0);
        tick();
        drive(6'b000001, 3'd2, 5'd10, 5'd6, 5'd0);
        bus.Branch_Taken_i = 1'b1;
        #1;
        check("fl_flush", {31'd0, bus.Flush_o}, 32'd1);
        check("fl_stall", {31'd0, bus.Stall_o}, 32'd0);
        tick();
        bus.Branch_Taken_i = 1'b0;
        drive(6'b000000, 3'd0, 5'd0, 5'd0, 5'd0);
        check("fl_bubble_ex", ex_all(), 32'd0);
        check("fl_mem", {26'd0, bus.Mem_Read_MEM_o, bus.Rd_MEM_o}, {26'd0, 1'b1, 5'd6});

        // Reset mid-stream with three bundles in flight
        drive(6'b000001, 3'd1, 5'd11, 5'd0, 5'd0);
        tick();
        drive(6'b000001, 3'd1, 5'd12, 5'd0, 5'd0);
        tick();
        drive(6'b000011, 3'd1, 5'd13, 5'd12, 5'd0);
        tick();
        check("pre_rst_fwd", {30'd0, bus.Forward_A_o}, {30'd0, FWD_MEM});
        drive(6'b000001, 3'd4, 5'd14, 5'd0, 5'd0);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_regs", regs_all(), 32'd0);
        check("rst_mid_comb", comb_all(), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        check("rst_rel_ex", ex_all(), 32'd0);
        tick();
        check("rst_first_ex", ex_all(), {22'd0, 1'b0, 1'b0, 3'd4, 5'd14});
        check("rst_no_mem", {26'd0, bus.Reg_Write_MEM_o, bus.Rd_MEM_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
